// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central sequencer for the five-stage pipeline registers.
// Drives per-register load enables and NOP-bubble flushes from hazard,
// branch, memory-handshake and halt conditions. It freezes the pipeline
// while data memory is busy, flags memory timeouts and counts stall cycles.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load_use                 load-use hazard in ID
//   branch_taken             taken branch/jump resolved in MEM
//   mem_req, mem_ready       MEM-stage data memory request / completion
//   halt                     ecall/ebreak/fence reached WB
//   pc_load..memwb_load      pipeline register load enables (Mealy)
//   ifid_flush..memwb_flush  insert NOP bubble instead of D (Mealy)
//   mem_err                  sticky memory timeout flag
//   stall_cnt                saturating count of cycles with pc_load=0
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt,
    output logic             pc_load,
    output logic             ifid_load,
    output logic             idex_load,
    output logic             exmem_load,
    output logic             memwb_load,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALTED   = 2'd2,
        S_ERR      = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TMO_W-1:0] r_tmo;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_wait_start;   // RUN cycle that begins a memory wait
    logic             w_wait_hold;    // MEM_WAIT cycle still without mem_ready
    logic             w_tmo_hit;
    logic             w_sel_freeze;
    logic             w_sel_normal;

    assign w_wait_start = (r_state == S_RUN) && !halt && mem_req && !mem_ready;
    assign w_wait_hold  = (r_state == S_MEM_WAIT) && !mem_ready;
    assign w_tmo_hit    = w_wait_hold && (r_tmo == TMO_W'(TIMEOUT));

    // Freeze: RUN rule 2 or a still-waiting MEM_WAIT cycle.
    assign w_sel_freeze = w_wait_start || w_wait_hold;
    // Branch/load-use/advance rules: plain RUN or the MEM_WAIT release cycle
    // (halt is deliberately not considered on release).
    assign w_sel_normal = ((r_state == S_RUN) && !halt && !(mem_req && !mem_ready))
                       || ((r_state == S_MEM_WAIT) && mem_ready);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (halt) begin
                    w_state_nxt = S_HALTED;
                end else if (mem_req && !mem_ready) begin
                    w_state_nxt = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (mem_ready) begin
                    w_state_nxt = S_RUN;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_HALTED: w_state_nxt = S_HALTED;
            S_ERR:    w_state_nxt = S_ERR;
            default:  w_state_nxt = S_RUN;
        endcase
    end

    // Output logic (Mealy), forced quiet while reset is asserted
    always_comb begin
        pc_load     = 1'b0;
        ifid_load   = 1'b0;
        idex_load   = 1'b0;
        exmem_load  = 1'b0;
        memwb_load  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (!rst) begin
            if (w_sel_freeze) begin
                // WB takes a bubble so the stalled instruction never re-commits.
                memwb_load  = 1'b1;
                memwb_flush = 1'b1;
            end else if (w_sel_normal) begin
                if (branch_taken) begin
                    pc_load     = 1'b1;
                    ifid_load   = 1'b1;
                    idex_load   = 1'b1;
                    exmem_load  = 1'b1;
                    memwb_load  = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (load_use) begin
                    idex_load   = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_load  = 1'b1;
                    memwb_load  = 1'b1;
                end else begin
                    pc_load     = 1'b1;
                    ifid_load   = 1'b1;
                    idex_load   = 1'b1;
                    exmem_load  = 1'b1;
                    memwb_load  = 1'b1;
                end
            end
        end
    end

    // Memory wait timeout counter: 1 on the first wait cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (w_wait_start) begin
            r_tmo <= TMO_W'(1);
        end else if (w_wait_hold && !w_tmo_hit) begin
            r_tmo <= r_tmo + TMO_W'(1);
        end else if (r_state == S_MEM_WAIT && mem_ready) begin
            r_tmo <= '0;
        end
    end

    // Sticky timeout flag, set on the edge that enters ERR
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_err <= 1'b0;
        end else if (w_tmo_hit) begin
            r_mem_err <= 1'b1;
        end
    end

    // Saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!pc_load && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed-vector bench for pipeline_ctrl with
// hand-computed load/flush patterns, stall counts and timeout behaviour.
module tb_pipeline_ctrl;

    localparam logic [8:0] C_ZERO   = 9'b00000_0000;
    localparam logic [8:0] C_ALL    = 9'b11111_0000;
    localparam logic [8:0] C_FREEZE = 9'b00001_0001;
    localparam logic [8:0] C_BRANCH = 9'b11111_1110;
    localparam logic [8:0] C_LDUSE  = 9'b00111_0100;

    logic        clk;
    logic        rst;
    logic        load_use;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        halt;
    logic        pc_load, ifid_load, idex_load, exmem_load, memwb_load;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic        mem_err;
    logic [31:0] stall_cnt;
    logic [8:0]  ctl;

    int n_vec  = 0;
    int n_miss = 0;

    pipeline_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_use     (load_use),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .halt         (halt),
        .pc_load      (pc_load),
        .ifid_load    (ifid_load),
        .idex_load    (idex_load),
        .exmem_load   (exmem_load),
        .memwb_load   (memwb_load),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .memwb_flush  (memwb_flush),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt)
    );

    assign ctl = {pc_load, ifid_load, idex_load, exmem_load, memwb_load,
                  ifid_flush, idex_flush, exmem_flush, memwb_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check Mealy outputs at the falling edge,
    // then advance past the rising edge.
    task automatic cyc(input string tag, input logic h, input logic mr, input logic rdy,
                       input logic br, input logic lu, input logic [8:0] exp);
        halt         = h;
        mem_req      = mr;
        mem_ready    = rdy;
        branch_taken = br;
        load_use     = lu;
        @(negedge clk);
        chk(tag, 32'(ctl), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        halt = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        branch_taken = 1'b0; load_use = 1'b0;
        @(posedge clk);
        #1;

        // Reset: outputs quiet even with hazards present
        cyc("rst_quiet", 0, 0, 0, 1, 0, C_ZERO);
        cyc("rst_quiet2", 0, 0, 0, 0, 0, C_ZERO);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        rst = 1'b0;
        chk("rst_stall", stall_cnt, 32'd0);

        for (int i = 0; i < 5; i++) cyc("run_idle", 0, 0, 0, 0, 0, C_ALL);
        chk("idle_stall", stall_cnt, 32'd0);

        // Single load-use bubble
        cyc("lduse", 0, 0, 0, 0, 1, C_LDUSE);
        cyc("lduse_after", 0, 0, 0, 0, 0, C_ALL);
        chk("lduse_stall", stall_cnt, 32'd1);

        // 3-cycle memory access -> 2 frozen cycles
        cyc("mem_w1", 0, 1, 0, 0, 0, C_FREEZE);
        cyc("mem_w2", 0, 1, 0, 0, 0, C_FREEZE);
        cyc("mem_rdy", 0, 1, 1, 0, 0, C_ALL);
        cyc("mem_after", 0, 0, 0, 0, 0, C_ALL);
        chk("mem_stall", stall_cnt, 32'd3);

        // Branch beats load-use in RUN
        cyc("br_lu", 0, 0, 0, 1, 1, C_BRANCH);
        cyc("br_after", 0, 0, 0, 0, 0, C_ALL);
        chk("br_stall", stall_cnt, 32'd3);

        // Branch + load-use held through a wait; acts on release, halt ignored
        cyc("brw_1", 0, 1, 0, 1, 1, C_FREEZE);
        cyc("brw_2", 0, 1, 0, 1, 1, C_FREEZE);
        cyc("brw_rel", 1, 1, 1, 1, 1, C_BRANCH);
        cyc("brw_after", 0, 0, 0, 0, 0, C_ALL);
        chk("brw_stall", stall_cnt, 32'd5);

        // Ready in the request cycle: no wait
        cyc("mem_fast", 0, 1, 1, 0, 0, C_ALL);
        cyc("fast_after", 0, 0, 0, 0, 0, C_ALL);
        chk("fast_stall", stall_cnt, 32'd5);

        // Timeout: 1 RUN + 16 MEM_WAIT frozen cycles, then ERR
        for (int i = 0; i < 20; i++) begin
            cyc("tmo_ctl", 0, 1, 0, 0, 0, (i < 17) ? C_FREEZE : C_ZERO);
            chk("tmo_mem_err", 32'(mem_err), (i >= 16) ? 32'd1 : 32'd0);
        end
        cyc("err_stuck", 0, 1, 1, 0, 0, C_ZERO);
        chk("err_stall", stall_cnt, 32'd26);
        chk("err_sticky", 32'(mem_err), 32'd1);
        rst = 1'b1;
        cyc("err_rst", 0, 0, 0, 0, 0, C_ZERO);
        rst = 1'b0;
        chk("err_clr", 32'(mem_err), 32'd0);
        chk("err_clr_stall", stall_cnt, 32'd0);

        // Halt wins over a memory request; HALTED is sticky
        cyc("halt", 1, 1, 0, 0, 0, C_ZERO);
        for (int i = 0; i < 10; i++) cyc("halted", 0, i[0], 1, 1, 0, C_ZERO);
        chk("halt_stall", stall_cnt, 32'd11);
        chk("halt_no_err", 32'(mem_err), 32'd0);
        rst = 1'b1;
        cyc("halt_rst", 0, 0, 0, 0, 0, C_ZERO);
        rst = 1'b0;
        cyc("halt_run", 0, 0, 0, 0, 0, C_ALL);
        chk("halt_run_stall", stall_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencer for the five-stage pipeline's inter-stage registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). Each cycle it drives every pipeline register's `load` enable and a per-stage `flush` that muxes a zero (NOP) bubble into the register's `D`. Inputs are hazard, branch, memory-handshake and halt conditions. It also freezes the pipeline while the data memory is busy, detects memory timeouts and counts stall cycles.

## Interface

Parameters:
- `TIMEOUT`, default 16: maximum consecutive MEM_WAIT cycles before `mem_err` is raised.
- `CNT_W`, default 32: width of `stall_cnt`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_use` in 1: load-use hazard detected in ID.
- `branch_taken` in 1: taken branch/jump resolved in MEM (from EX/MEM).
- `mem_req` in 1: the MEM-stage instruction accesses data memory.
- `mem_ready` in 1: data memory completes the access this cycle.
- `halt` in 1: ecall/ebreak/fence reached WB.
- `pc_load`, `ifid_load`, `idex_load`, `exmem_load`, `memwb_load` out 1 each: register load enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush` out 1 each: load a NOP bubble instead of `D`. These are only meaningful with the matching load=1.
- `mem_err` out 1: sticky memory timeout flag.
- `stall_cnt` out CNT_W: count of non-advancing PC cycles.

## Operation

FSM states are RUN, MEM_WAIT, HALTED and ERR. Outputs are Mealy: combinational from the current state and inputs.

In RUN, the decision takes the first matching condition in this priority order:
1. `halt`:
   - all loads 0.
   - next state HALTED.
2. `mem_req & !mem_ready`:
   - `pc/ifid/idex/exmem_load` = 0.
   - `memwb_load` = 1 and `memwb_flush` = 1, so WB sees a bubble and never re-commits.
   - next state MEM_WAIT; timeout counter set to 1.
3. `branch_taken`:
   - all loads 1.
   - `ifid_flush`, `idex_flush` and `exmem_flush` = 1.
4. `load_use`:
   - `pc_load` = 0 and `ifid_load` = 0.
   - `idex_load` = 1 and `idex_flush` = 1.
   - `exmem/memwb_load` = 1.
5. Otherwise: all loads 1, all flushes 0.

In MEM_WAIT:
- If `mem_ready=0`:
  - freeze outputs exactly as RUN rule 2.
  - timeout counter increments.
  - when the counter reaches TIMEOUT with `mem_ready` still 0, the next state is ERR.
- If `mem_ready=1`:
  - outputs follow RUN rules 3–5 evaluated on the current inputs; `halt` is ignored this cycle.
  - next state RUN.
- Held `branch_taken` and `load_use` are therefore acted on in the release cycle.

HALTED and ERR:
- All loads 0 and all flushes 0.
- Both states are exit-only by `rst`.
- `mem_err` = 1 in ERR.

`stall_cnt`:
- Increments every cycle with `pc_load=0`, in any state including HALTED and ERR.
- Saturates at all-ones.

While `rst=1`:
- All load and flush outputs are forced to 0, regardless of state.
- At the clock edge: state becomes RUN, the timeout counter becomes 0, `stall_cnt` becomes 0 and `mem_err` becomes 0.

Reset mid-MEM_WAIT abandons the access; the memory side is reset by the same `rst`.

## Timing

- Zero-cycle latency: the freeze, flush or stall takes effect on the same clock edge as the triggering input.
- Load-use costs exactly 1 bubble. The hazard unit deasserts `load_use` the next cycle because ID/EX now holds a NOP.
- A taken branch costs 3 flushed slots and a single cycle of controller activity.
- A memory access taking k cycles (`mem_ready` in the k-th cycle of `mem_req`) produces k-1 frozen cycles.
- `mem_ready` asserted in the same cycle as `mem_req` in RUN causes no wait.
- Timeout: when `mem_ready` never arrives, ERR is entered on the edge ending the TIMEOUT-th MEM_WAIT cycle. `mem_err` is high from the next cycle.
- Simultaneous `branch_taken` & `load_use`: the branch wins and no stall is taken; the load-use instruction is flushed anyway.
- Simultaneous `halt` & `mem_req`: halt wins.

## Test plan

- Reset, then no hazards for 5 cycles:
  - during reset, all outputs 0.
  - afterwards, all loads 1, all flushes 0, `stall_cnt`=0.
- Single `load_use` pulse:
  - that cycle `pc_load`=`ifid_load`=0, `idex_flush`=1.
  - next cycle all loads 1.
  - `stall_cnt`=1.
- `mem_req`=1 with `mem_ready` rising on the 3rd cycle:
  - 2 frozen cycles with `memwb_flush`=1, then normal loads.
  - `stall_cnt`=2.
- `branch_taken` and `load_use` together, also repeated during MEM_WAIT:
  - only `ifid/idex/exmem_flush`=1 with `pc_load`=1.
  - in MEM_WAIT the branch acts in the `mem_ready` cycle.
- `mem_req`=1 and `mem_ready`=0 for 20 cycles, TIMEOUT=16:
  - ERR entered after 16 wait cycles, then `mem_err`=1 and all loads 0.
  - asserting `rst` clears `mem_err`.
- `halt` pulse while `mem_req`=1:
  - HALTED is entered; all loads stay 0 for 10 cycles.
  - `stall_cnt` increments every cycle; reset returns to RUN.
